// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO read-side drain engine.
package fifo_rd_pkg;

  // Drain engine FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  // Bit width needed to index n entries; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_BUF_DEPTH = 2;
  localparam int unsigned DEF_FRAME_LEN = 16;
  localparam int unsigned PTR_W  = ptr_width(DEF_BUF_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FCNT_W = ptr_width(DEF_FRAME_LEN);

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by the drain engine.
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_vld;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  // Drain engine side.
  modport master (
    input  fifo_empty, fifo_rd_data, fifo_rd_vld, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  // FIFO + downstream consumer side.
  modport slave (
    output fifo_empty, fifo_rd_data, fifo_rd_vld, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_rd_buf.sv
// Circular prefetch buffer: absorbs FIFO returns, presents the oldest word at head.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned AW    = PTR_W,
  parameter int unsigned CW    = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [CW-1:0]    occ,
  output logic [WIDTH-1:0] head
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    do_push  = push & (occ_q != DEPTH_C);
    do_pop   = pop & (occ_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      occ_d = occ_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Data storage carries no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign full = (occ_q == DEPTH_C);
  assign occ  = occ_q;
  assign head = (occ_q == '0) ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: credit-limited FIFO reads re-presented as a framed valid/ready stream.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic             rd_clk,
  input  logic             rest,
  input  logic             en,
  input  logic             flush,
  fifo_rd_stream_if.master bus,
  output logic             busy,
  output logic             err_ovf
);

  localparam int unsigned   AW       = ptr_width(BUF_DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam int unsigned   FW       = ptr_width(FRAME_LEN);
  localparam logic [CW:0]   DEPTH_X  = (CW + 1)'(BUF_DEPTH);
  localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          err_q, err_d;

  logic             buf_full;
  logic [CW-1:0]    occ;
  logic [WIDTH-1:0] head;
  logic             in_flush, m_valid, pop, ret, push, clear, rd_en;
  logic [CW:0]      committed;

  // Issue/credit logic. committed counts buffered plus in-flight words net of
  // this cycle's pop, so m_ready reaches fifo_rd_en combinationally.
  always_comb begin
    in_flush  = (state_q == ST_FLUSH);
    m_valid   = (occ != '0) & ~in_flush;
    pop       = m_valid & bus.m_ready;
    ret       = bus.fifo_rd_vld & (outst_q != '0);
    push      = ret & ~in_flush & ~buf_full;
    committed = {1'b0, occ} + {1'b0, outst_q} - {{CW{1'b0}}, pop};
    rd_en     = (state_q == ST_RUN) & ~bus.fifo_empty & (committed < DEPTH_X);
    clear     = in_flush & (outst_q == '0);
  end

  // FSM: flush has priority; FLUSH waits for every outstanding read to return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush)   state_d = ST_FLUSH;
        else if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush)    state_d = ST_FLUSH;
        else if (!en) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (outst_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outstanding-read credit, frame position and sticky overflow flag.
  always_comb begin
    outst_d = outst_q + CW'(rd_en) - CW'(ret);
    fcnt_d  = fcnt_q;
    if (clear) begin
      fcnt_d = '0;
    end else if (pop) begin
      fcnt_d = (fcnt_q == LAST_IDX) ? '0 : fcnt_q + 1'b1;
    end
    err_d = err_q | (ret & ~in_flush & buf_full);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge rd_clk) begin
    if (rest) begin
      state_q <= ST_IDLE;
      outst_q <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  fifo_rd_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rest),
    .clear     (clear),
    .push      (push),
    .push_data (bus.fifo_rd_data),
    .pop       (pop),
    .full      (buf_full),
    .occ       (occ),
    .head      (head)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = head;
  assign bus.m_last     = m_valid & (fcnt_q == LAST_IDX);
  assign busy           = (state_q != ST_IDLE) | (occ != '0) | (outst_q != '0);
  assign err_ovf        = err_q;

endmodule
